// File: rtl/div_pkg.sv
// Shared execute-stage definitions for the divider: FSM state encodings,
// request levels and result-ready levels.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div.sv
// Multi-cycle restoring radix-2 divider for the execute stage.
// Operands are captured as magnitudes on the accepting edge, WIDTH trial
// subtractions follow, then the signs are applied and {remainder, quotient}
// is held in END until the execute stage drops its request.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e         state_reg, state_next;
  logic [WIDTH-1:0]   dividend_reg, dividend_next;  // shifts quotient bits in at the bottom
  logic [WIDTH-1:0]   divisor_reg, divisor_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;            // partial remainder
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               neg_q_reg, neg_q_next;
  logic               neg_r_reg, neg_r_next;
  logic [2*WIDTH-1:0] result_reg, result_next;
  logic               ready_reg, ready_next;

  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     partial;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Magnitudes of the operands; -0x80000000 wraps to 0x80000000, which is
  // the correct unsigned magnitude, so the overflow case needs no trap.
  assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // Trial subtract: since rem < divisor, the (WIDTH+1)-bit difference has
  // its top bit set exactly when the divisor does not fit.
  assign partial  = {rem_reg, dividend_reg[WIDTH-1]};
  assign trial    = partial - {1'b0, divisor_reg};
  assign quot_fix = neg_q_reg ? -dividend_reg : dividend_reg;
  assign rem_fix  = neg_r_reg ? -rem_reg : rem_reg;

  // Next-state, datapath and output decode
  always_comb begin
    state_next    = state_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    rem_next      = rem_reg;
    cnt_next      = cnt_reg;
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
    result_next   = '0;
    ready_next    = DivResultNotReady;
    case (state_reg)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          cnt_next = '0;
          if (opdata2_i == '0) begin
            state_next = DivByZero;
          end else begin
            state_next    = DivOn;
            dividend_next = abs1;
            divisor_next  = abs2;
            rem_next      = '0;
            neg_q_next    = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r_next    = signed_div_i && opdata1_i[WIDTH-1];
          end
        end
      end
      DivByZero: begin
        // Dwells two edges so a zero divide reports two edges after acceptance
        if (annul_i) begin
          state_next = DivFree;
        end else if (cnt_reg == '0) begin
          cnt_next = CW'(1);
        end else begin
          state_next = DivEnd;
          ready_next = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_next = DivFree;
        end else if (cnt_reg == CW'(WIDTH)) begin
          state_next  = DivEnd;
          result_next = {rem_fix, quot_fix};
          ready_next  = DivResultReady;
        end else begin
          cnt_next = cnt_reg + CW'(1);
          if (!trial[WIDTH]) begin
            rem_next      = trial[WIDTH-1:0];
            dividend_next = {dividend_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_next      = partial[WIDTH-1:0];
            dividend_next = {dividend_reg[WIDTH-2:0], 1'b0};
          end
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_next = DivFree;
        end else begin
          result_next = result_reg;
          ready_next  = DivResultReady;
        end
      end
      default: state_next = DivFree;
    endcase
  end

  // State and datapath registers, cleared immediately by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= DivFree;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      rem_reg      <= '0;
      cnt_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      result_reg   <= '0;
      ready_reg    <= DivResultNotReady;
    end else begin
      state_reg    <= state_next;
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      rem_reg      <= rem_next;
      cnt_reg      <= cnt_next;
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
      result_reg   <= result_next;
      ready_reg    <= ready_next;
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: the driver pushes the expected result and
// latency per request; a monitor pops and compares on each ready_o rise.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  div #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference: plain integer division; truncating / and % give the
  // remainder the sign of the dividend. Zero divisor yields 0.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every ready_o rise must match the oldest outstanding request
  initial begin
    exp_t e;
    logic ready_prev;
    ready_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_o === 1'b1 && ready_prev !== 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready: got result %h with no request outstanding", result_o);
        end else begin
          e = q.pop_front();
          chk({e.name, "_result"}, result_o, e.res);
          chk({e.name, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
          $display("txn %s result=%h latency=%0d", e.name, result_o, cyc - e.acc);
        end
      end
      ready_prev = ready_o;
    end
  end

  // Full request: issue, scramble operands while busy, hold in END with
  // random annul, then release and check the outputs clear.
  task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [63:0] exp_res;
    exp_t        e;
    int          waited;
    exp_res = model(sgn, a, b);
    @(posedge clk); #1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    e.res  = exp_res;
    e.acc  = cyc + 1;
    e.lat  = (b == 32'd0) ? 2 : 33;
    e.name = name;
    q.push_back(e);
    @(posedge clk); #1;
    waited = 0;
    while (ready_o !== 1'b1 && waited < 100) begin
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      waited++;
    end
    if (ready_o !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got ready_o=%b want 1 within 100 cycles", name, ready_o);
      q.delete();
    end else begin
      repeat ($urandom_range(1, 3)) begin
        annul_i = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        chk({name, "_hold_ready"}, 64'(ready_o), 64'd1);
        chk({name, "_hold_result"}, result_o, exp_res);
      end
    end
    start_i = 1'b0;
    annul_i = 1'b0;
    @(posedge clk); #1;
    chk({name, "_release_ready"}, 64'(ready_o), 64'd0);
    chk({name, "_release_result"}, result_o, 64'd0);
  endtask

  initial begin
    int          waited;
    exp_t        e;
    bit          sgn;
    logic [31:0] a, b;
    int          sel;

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #12;
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    do_op(1'b0, 32'd100, 32'd7, "u_100_7");
    chk("u_100_7_const", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    do_op(1'b1, 32'hFFFFFFF9, 32'd2, "s_m7_2");
    do_op(1'b1, 32'd7, 32'hFFFFFFFE, "s_7_m2");
    do_op(1'b0, 32'd5, 32'd0, "u_5_0");
    do_op(1'b1, 32'd5, 32'd0, "s_5_0");
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, "s_min_m1");

    // Annul at the 10th ON edge: no result, then a normal request
    @(posedge clk); #1;
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (8) @(posedge clk);
    #1 annul_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    chk("annul_on_ready", 64'(ready_o), 64'd0);
    repeat (40) @(posedge clk);
    #1 chk("annul_on_quiet", 64'(ready_o), 64'd0);
    do_op(1'b0, 32'hFFFFFFFF, 32'h10, "u_ffffffff_10");

    // Annul has priority over start in FREE
    @(posedge clk); #1;
    opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 start_i = 1'b0;
    annul_i = 1'b0;
    repeat (40) @(posedge clk);
    #1 chk("annul_free_quiet", 64'(ready_o), 64'd0);

    // Annul while dividing by zero
    @(posedge clk); #1;
    opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("annul_byzero_quiet", 64'(ready_o), 64'd0);

    // Reset at the 15th ON edge
    @(posedge clk); #1;
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    start_i = 1'b0;
    #1;
    chk("rst_on_ready", 64'(ready_o), 64'd0);
    chk("rst_on_result", result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1 chk("rst_on_quiet", 64'(ready_o), 64'd0);
    do_op(1'b0, 32'd9, 32'd3, "u_9_3");

    // Reset while holding a result: outputs clear before any clock edge
    @(posedge clk); #1;
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    e.res = model(1'b0, 32'd1000, 32'd3); e.acc = cyc + 1; e.lat = 33; e.name = "u_1000_3";
    q.push_back(e);
    @(posedge clk); #1;
    waited = 0;
    while (ready_o !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("rst_end_pre_ready", 64'(ready_o), 64'd1);
    if (ready_o !== 1'b1) q.delete();
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_end_ready", 64'(ready_o), 64'd0);
    chk("rst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized requests
    for (int n = 0; n < 40; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3:       b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      do_op(sgn, a, b, $sformatf("rnd%0d", n));
    end

    repeat (5) @(posedge clk);
    #1 chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
